// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard control unit: branch codes, FSM states,
// default register-address width and the branch-taken decode.
package hazard_pkg;

   localparam int HZ_REG_AW = 5;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_BEQ  = 2'b01;
   localparam logic [1:0] BR_BNE  = 2'b10;
   localparam logic [1:0] BR_JMP  = 2'b11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STALL = 2'd1,
      FLUSH = 2'd2
   } hz_state_e;

   function automatic logic br_taken(input logic [1:0] br, input logic eq);
      logic t;
      t = 1'b0;
      case (br)
         BR_NONE: t = 1'b0;
         BR_BEQ:  t = eq;
         BR_BNE:  t = ~eq;
         BR_JMP:  t = 1'b1;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter: counts cycles with inc high, sticks at all-ones.
module hazard_sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [CNT_W-1:0] cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != '1)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/hazard_control_unit.sv
// Load-use stall / branch flush controller between IF/ID and ID/EX.
// Optional stall/flush cycle counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | outputs decoded combinationally from the current ID/EX inputs
// STALL | holding PC and IF/ID, bubbling ID/EX for the rest of a load-use stall
// FLUSH | clearing IF/ID for the rest of a taken branch/jump
module hazard_control_unit
   import hazard_pkg::*;
#(
   parameter int REG_AW      = HZ_REG_AW,
   parameter int LOAD_LAT    = 1,
   parameter int FLUSH_DEPTH = 1,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ID_EX_mem_read,
   input  logic [REG_AW-1:0] ID_EX_rt,
   input  logic [REG_AW-1:0] IF_ID_rs,
   input  logic [REG_AW-1:0] IF_ID_rt,
   input  logic [1:0]        branch,
   input  logic              equal,
   output logic              pc_write,
   output logic              IF_ID_write,
   output logic              mux_hz_unit,
   output logic              flush,
   output logic              busy
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`endif
);

   localparam int MAX_LEN = (LOAD_LAT > FLUSH_DEPTH) ? LOAD_LAT : FLUSH_DEPTH;
   localparam int CW      = $clog2(MAX_LEN) + 1;

   // The first hazard cycle is spent in IDLE, so the counter covers the remainder.
   localparam logic [CW-1:0] STALL_INIT = CW'((LOAD_LAT > 1) ? LOAD_LAT - 2 : 0);
   localparam logic [CW-1:0] FLUSH_INIT = CW'((FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0);

   hz_state_e       state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            hz;
   logic            taken;

   assign hz = ID_EX_mem_read && (ID_EX_rt != '0) &&
               ((IF_ID_rs == ID_EX_rt) || (IF_ID_rt == ID_EX_rt));
   assign taken = br_taken(branch, equal);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_write    = 1'b1;
      IF_ID_write = 1'b1;
      mux_hz_unit = 1'b1;
      flush       = 1'b0;
      busy        = 1'b0;
      case (state_q)
         IDLE: begin
            if (hz) begin
               pc_write    = 1'b0;
               IF_ID_write = 1'b0;
               mux_hz_unit = 1'b0;
               if (LOAD_LAT > 1) begin
                  state_d = STALL;
                  cnt_d   = STALL_INIT;
               end
            end else if (taken) begin
               flush = 1'b1;
               if (FLUSH_DEPTH > 1) begin
                  state_d = FLUSH;
                  cnt_d   = FLUSH_INIT;
               end
            end
         end
         STALL: begin
            pc_write    = 1'b0;
            IF_ID_write = 1'b0;
            mux_hz_unit = 1'b0;
            busy        = 1'b1;
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         FLUSH: begin
            flush = 1'b1;
            busy  = 1'b1;
            if (cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst),
      .inc   (~pc_write),
      .cnt   (stall_cnt)
   );

   hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst),
      .inc   (flush),
      .cnt   (flush_cnt)
   );
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: three instances with different stall/flush
// lengths share one stimulus stream and are compared against a cycle-count model.
module tb_hazard_control_unit;

   localparam int NDUT = 3;

   logic       clk;
   logic       rst;
   logic       mem_read;
   logic [4:0] ex_rt;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [1:0] br;
   logic       eq;

   logic [NDUT-1:0] pc_w, ifid_w, mux_w, fl_w, busy_w;
   logic [1:0] sc [NDUT];
   logic [1:0] fc [NDUT];

   int vectors;
   int miscompares;

   // Model: cycles still owed to the current sequence, and whether it is a stall.
   int rem [NDUT];
   bit stl [NDUT];
   int sc_m;
   int fc_m;

   function automatic int ll(input int k);
      return (k == 0) ? 1 : (k == 1) ? 3 : 4;
   endfunction

   function automatic int fd(input int k);
      return (k == 2) ? 1 : 2;
   endfunction

   hazard_control_unit #(.REG_AW(5), .LOAD_LAT(1), .FLUSH_DEPTH(2), .CNT_W(2)) u_dut0 (
      .clk(clk), .rst(rst), .ID_EX_mem_read(mem_read), .ID_EX_rt(ex_rt),
      .IF_ID_rs(id_rs), .IF_ID_rt(id_rt), .branch(br), .equal(eq),
      .pc_write(pc_w[0]), .IF_ID_write(ifid_w[0]), .mux_hz_unit(mux_w[0]),
      .flush(fl_w[0]), .busy(busy_w[0])
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(sc[0]), .flush_cnt(fc[0])
`endif
   );

   hazard_control_unit #(.REG_AW(5), .LOAD_LAT(3), .FLUSH_DEPTH(2), .CNT_W(2)) u_dut1 (
      .clk(clk), .rst(rst), .ID_EX_mem_read(mem_read), .ID_EX_rt(ex_rt),
      .IF_ID_rs(id_rs), .IF_ID_rt(id_rt), .branch(br), .equal(eq),
      .pc_write(pc_w[1]), .IF_ID_write(ifid_w[1]), .mux_hz_unit(mux_w[1]),
      .flush(fl_w[1]), .busy(busy_w[1])
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(sc[1]), .flush_cnt(fc[1])
`endif
   );

   hazard_control_unit #(.REG_AW(5), .LOAD_LAT(4), .FLUSH_DEPTH(1), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .ID_EX_mem_read(mem_read), .ID_EX_rt(ex_rt),
      .IF_ID_rs(id_rs), .IF_ID_rt(id_rt), .branch(br), .equal(eq),
      .pc_write(pc_w[2]), .IF_ID_write(ifid_w[2]), .mux_hz_unit(mux_w[2]),
      .flush(fl_w[2]), .busy(busy_w[2])
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt(sc[2]), .flush_cnt(fc[2])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit hz_now();
      return mem_read && (ex_rt != 0) && ((id_rs == ex_rt) || (id_rt == ex_rt));
   endfunction

   function automatic bit taken_now();
      return (br == 2'b01 && eq) || (br == 2'b10 && !eq) || (br == 2'b11);
   endfunction

   function automatic bit m_stalling(input int k);
      return (rem[k] > 0) ? stl[k] : hz_now();
   endfunction

   function automatic bit m_flushing(input int k);
      return (rem[k] > 0) ? !stl[k] : (!hz_now() && taken_now());
   endfunction

   // {pc_write, IF_ID_write, mux_hz_unit, flush, busy}
   function automatic logic [4:0] model_out(input int k);
      bit s;
      s = m_stalling(k);
      return {!s, !s, !s, m_flushing(k), rem[k] > 0};
   endfunction

   function automatic logic [4:0] obs(input int k);
      return {pc_w[k], ifid_w[k], mux_w[k], fl_w[k], busy_w[k]};
   endfunction

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NDUT; k++) begin
            rem[k] <= 0;
            stl[k] <= 1'b0;
         end
         sc_m <= 0;
         fc_m <= 0;
      end else begin
         if (m_stalling(0) && sc_m < 3) sc_m <= sc_m + 1;
         if (m_flushing(0) && fc_m < 3) fc_m <= fc_m + 1;
         for (int k = 0; k < NDUT; k++) begin
            if (rem[k] > 0) begin
               rem[k] <= rem[k] - 1;
            end else if (hz_now()) begin
               rem[k] <= ll(k) - 1;
               stl[k] <= 1'b1;
            end else if (taken_now()) begin
               rem[k] <= fd(k) - 1;
               stl[k] <= 1'b0;
            end
         end
      end
   end

   task automatic drive(input logic m, input logic [4:0] ert, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [1:0] b, input logic e);
      mem_read = m;
      ex_rt    = ert;
      id_rs    = rs;
      id_rt    = rt;
      br       = b;
      eq       = e;
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #1;
      for (int k = 0; k < NDUT; k++) begin
         vectors++;
         if (obs(k) !== 5'b11100) begin
            miscompares++;
            $display("FAIL reset_outputs dut%0d got=%b exp=%b", k, obs(k), 5'b11100);
         end
`ifdef HAZARD_PERF_CNT_EN
         vectors++;
         if (sc[k] !== 2'd0 || fc[k] !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_counters dut%0d got=%0d/%0d exp=0/0", k, sc[k], fc[k]);
         end
`endif
      end
   endtask

   task automatic test_load_use();
      int pc_low [NDUT];
      int busy_hi [NDUT];
      for (int k = 0; k < NDUT; k++) begin
         pc_low[k] = 0;
         busy_hi[k] = 0;
      end
      for (int c = 0; c < 7; c++) begin
         if (c == 0) drive(1'b1, 5'd8, 5'd8, 5'd2, 2'b00, 1'b0);
         else        drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
         #2;
         for (int k = 0; k < NDUT; k++) begin
            vectors++;
            if (obs(k) !== model_out(k)) begin
               miscompares++;
               $display("FAIL load_use dut%0d cyc=%0d got=%b exp=%b", k, c, obs(k), model_out(k));
            end
            if (!pc_w[k]) pc_low[k]++;
            if (busy_w[k]) busy_hi[k]++;
         end
         @(negedge clk);
      end
      vectors++;
      if (pc_low[0] != 1 || busy_hi[0] != 0) begin
         miscompares++;
         $display("FAIL load_lat1_len got=%0d/%0d exp=1/0", pc_low[0], busy_hi[0]);
      end
      vectors++;
      if (pc_low[1] != 3 || busy_hi[1] != 2) begin
         miscompares++;
         $display("FAIL load_lat3_len got=%0d/%0d exp=3/2", pc_low[1], busy_hi[1]);
      end
      // A load into register 0 never creates a hazard.
      drive(1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
      #2;
      for (int k = 0; k < NDUT; k++) begin
         vectors++;
         if (obs(k) !== 5'b11100) begin
            miscompares++;
            $display("FAIL load_r0 dut%0d got=%b exp=%b", k, obs(k), 5'b11100);
         end
      end
      @(negedge clk);
   endtask

   task automatic test_branch();
      logic [1:0] bcode [4] = '{2'b01, 2'b01, 2'b10, 2'b11};
      logic       bequ  [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
      int         want  [4] = '{2, 0, 2, 2};
      int         nfl;
      for (int t = 0; t < 4; t++) begin
         nfl = 0;
         for (int c = 0; c < 4; c++) begin
            if (c == 0) drive(1'b0, 5'd0, 5'd1, 5'd2, bcode[t], bequ[t]);
            else        drive(1'b0, 5'd0, 5'd1, 5'd2, 2'b00, 1'b0);
            #2;
            for (int k = 0; k < NDUT; k++) begin
               vectors++;
               if (obs(k) !== model_out(k)) begin
                  miscompares++;
                  $display("FAIL branch%0d dut%0d cyc=%0d got=%b exp=%b", t, k, c, obs(k), model_out(k));
               end
            end
            if (fl_w[0]) nfl++;
            @(negedge clk);
         end
         vectors++;
         if (nfl != want[t]) begin
            miscompares++;
            $display("FAIL branch%0d_flush_len got=%0d exp=%0d", t, nfl, want[t]);
         end
      end
   endtask

   task automatic test_priority();
      for (int c = 0; c < 6; c++) begin
         if (c == 0) drive(1'b1, 5'd5, 5'd1, 5'd5, 2'b11, 1'b0);
         else        drive(1'b0, 5'd0, 5'd1, 5'd5, 2'b11, 1'b0);
         #2;
         for (int k = 0; k < NDUT; k++) begin
            vectors++;
            if (obs(k) !== model_out(k)) begin
               miscompares++;
               $display("FAIL priority dut%0d cyc=%0d got=%b exp=%b", k, c, obs(k), model_out(k));
            end
         end
         if (c == 0) begin
            vectors++;
            if (obs(0) !== 5'b00000) begin
               miscompares++;
               $display("FAIL priority_stall_only got=%b exp=%b", obs(0), 5'b00000);
            end
         end
         if (c == 1) begin
            vectors++;
            if (obs(0) !== 5'b11110) begin
               miscompares++;
               $display("FAIL priority_flush_after got=%b exp=%b", obs(0), 5'b11110);
            end
         end
         @(negedge clk);
      end
      drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
      repeat (4) @(negedge clk);
   endtask

   task automatic test_reset_mid_stall();
      reset_pulse();
      drive(1'b1, 5'd7, 5'd7, 5'd0, 2'b00, 1'b0);
      @(negedge clk);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
      #2;
      vectors++;
      if (obs(2) !== 5'b00001) begin
         miscompares++;
         $display("FAIL mid_stall_pre got=%b exp=%b", obs(2), 5'b00001);
      end
      rst = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         vectors++;
         if (obs(k) !== 5'b11100) begin
            miscompares++;
            $display("FAIL mid_stall_abort dut%0d got=%b exp=%b", k, obs(k), 5'b11100);
         end
      end
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #2;
         for (int k = 0; k < NDUT; k++) begin
            vectors++;
            if (obs(k) !== 5'b11100) begin
               miscompares++;
               $display("FAIL mid_stall_residual dut%0d cyc=%0d got=%b exp=%b", k, c, obs(k), 5'b11100);
            end
         end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back();
      int pc_low;
      pc_low = 0;
      for (int c = 0; c < 8; c++) begin
         if (c < 7) drive(1'b1, 5'd3, 5'd3, 5'd3, 2'b11, 1'b1);
         else       drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
         #2;
         for (int k = 0; k < NDUT; k++) begin
            vectors++;
            if (obs(k) !== model_out(k)) begin
               miscompares++;
               $display("FAIL back_to_back dut%0d cyc=%0d got=%b exp=%b", k, c, obs(k), model_out(k));
            end
         end
         if (c < 7 && !pc_w[1]) pc_low++;
         @(negedge clk);
      end
      vectors++;
      if (pc_low != 7) begin
         miscompares++;
         $display("FAIL back_to_back_gap got=%0d exp=7", pc_low);
      end
      repeat (4) @(negedge clk);
   endtask

   task automatic test_perf();
      reset_pulse();
      repeat (5) begin
         drive(1'b1, 5'd9, 5'd9, 5'd0, 2'b00, 1'b0);
         @(negedge clk);
      end
      drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
      #2;
`ifdef HAZARD_PERF_CNT_EN
      vectors++;
      if (sc[0] !== 2'd3 || fc[0] !== 2'd0) begin
         miscompares++;
         $display("FAIL perf_stall_sat got=%0d/%0d exp=3/0", sc[0], fc[0]);
      end
`endif
      @(negedge clk);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b11, 1'b0);
      @(negedge clk);
      drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
      repeat (3) @(negedge clk);
      #2;
`ifdef HAZARD_PERF_CNT_EN
      vectors++;
      if (fc[0] !== 2'd2 || fc[0] !== fc_m[1:0]) begin
         miscompares++;
         $display("FAIL perf_flush got=%0d exp=2", fc[0]);
      end
      vectors++;
      if (sc[0] !== sc_m[1:0]) begin
         miscompares++;
         $display("FAIL perf_stall_model got=%0d exp=%0d", sc[0], sc_m);
      end
`endif
      for (int k = 0; k < NDUT; k++) begin
         vectors++;
         if (obs(k) !== model_out(k)) begin
            miscompares++;
            $display("FAIL perf_outputs dut%0d got=%b exp=%b", k, obs(k), model_out(k));
         end
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         #2;
         for (int k = 0; k < NDUT; k++) begin
            vectors++;
            if (obs(k) !== model_out(k)) begin
               miscompares++;
               $display("FAIL random dut%0d cyc=%0d got=%b exp=%b", k, c, obs(k), model_out(k));
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b0;
      drive(1'b0, 5'd0, 5'd0, 5'd0, 2'b00, 1'b0);
      test_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      test_load_use();
      test_branch();
      test_priority();
      test_reset_mid_stall();
      test_back_to_back();
      test_perf();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Parametrised successor of the pipeline data/control hazard detector. It sits between the IF/ID and ID/EX pipeline registers.
- Generates load-use stalls of configurable length (LOAD_LAT cycles) and branch/jump flushes of configurable depth (FLUSH_DEPTH cycles).
- A small FSM holds stalls and flushes across cycles. Loads targeting register 0 are ignored.
- Optional performance counters report stall and flush cycle totals.

Parameters:
- REG_AW, 5: register-address width.
- LOAD_LAT, 1: total stall cycles per load-use hazard (>=1).
- FLUSH_DEPTH, 1: total flush cycles per taken branch/jump (>=1).
- CNT_W, 16: performance-counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- ID_EX_mem_read  input  1  instruction in EX is a load.
- ID_EX_rt  input  REG_AW  destination register of the load in EX.
- IF_ID_rs  input  REG_AW  rs of the instruction in ID.
- IF_ID_rt  input  REG_AW  rt of the instruction in ID.
- branch  input  2  00 none, 01 beq, 10 bne, 11 jump.
- equal  input  1  ID-stage comparator result.
- pc_write  output  1  0 = hold PC.
- IF_ID_write  output  1  0 = hold IF/ID.
- mux_hz_unit  output  1  0 = inject bubble (zero control) into ID/EX.
- flush  output  1  1 = clear IF/ID.
- busy  output  1  FSM not in IDLE.
- stall_cnt  output  CNT_W  only with the feature enabled.
- flush_cnt  output  CNT_W  only with the feature enabled.

Behaviour:
- Reset values (rst=0, asynchronous):
  - state=IDLE, cycle counter=0.
  - pc_write=1, IF_ID_write=1, mux_hz_unit=1, flush=0, busy=0.
  - Perf counters=0.
- Hazard terms:
  - hz = ID_EX_mem_read & (ID_EX_rt != 0) & (IF_ID_rs == ID_EX_rt | IF_ID_rt == ID_EX_rt).
  - taken = (branch==01 & equal) | (branch==10 & !equal) | (branch==11).
- States: IDLE, STALL, FLUSH. Internal down-counter width = $clog2(max(LOAD_LAT,FLUSH_DEPTH))+1.
- IDLE:
  - Outputs are combinational from the inputs, with zero latency.
  - If hz: pc_write=IF_ID_write=mux_hz_unit=0 and flush=0. Branch evaluation is suppressed, because the ID operands are stale. If LOAD_LAT>1, go to STALL with counter=LOAD_LAT-2.
  - Else if taken: flush=1, all write enables 1. If FLUSH_DEPTH>1, go to FLUSH with counter=FLUSH_DEPTH-2.
  - hz has priority over taken when both occur in the same cycle.
- STALL:
  - Outputs are registered-state driven: pc_write=IF_ID_write=mux_hz_unit=0, flush=0, busy=1.
  - All inputs are ignored.
  - When counter==0, return to IDLE; otherwise decrement.
  - After return, the held ID instruction is re-evaluated in IDLE, so a branch is resolved then.
- FLUSH:
  - Outputs: flush=1, write enables=1, busy=1. Inputs are ignored, since ID holds a squashed slot.
  - When counter==0, return to IDLE; otherwise decrement.
- Outputs are fully defined in every state (no latches). No sensitivity to unused inputs.
- Reset asserted mid-STALL/FLUSH aborts immediately to IDLE with default outputs.
- Back-to-back: a hazard detected in the first IDLE cycle after STALL/FLUSH starts a new sequence with no gap cycle.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cnt increments every cycle pc_write==0.
  - flush_cnt increments every cycle flush==1.
  - Both saturate at all-ones and never wrap.
  - Both reset to 0 on rst=0.
- Undefined: stall_cnt/flush_cnt ports and logic are absent.

Decomposition:
- Shared package hazard_pkg:
  - Branch-code constants BR_NONE=2'b00, BR_BEQ=2'b01, BR_BNE=2'b10, BR_JMP=2'b11.
  - FSM state enum {IDLE, STALL, FLUSH}.
  - Default REG_AW constant.
- One natural sub-module, hazard_sat_counter (CNT_W-wide saturating incrementer with async active-low reset). It is instantiated twice under HAZARD_PERF_CNT_EN.
- All other logic stays flat.

Test Plan:
- LOAD_LAT=1: mem_read=1, ID_EX_rt=8, IF_ID_rs=8 for one cycle -> pc_write=IF_ID_write=mux_hz_unit=0 that cycle only, busy=0. ID_EX_rt=0, IF_ID_rs=0 -> no stall.
- LOAD_LAT=3: same hazard pulsed one cycle -> enables low for exactly 3 consecutive cycles, busy=1 on cycles 2-3, then IDLE.
- FLUSH_DEPTH=2:
  - branch=01, equal=1 -> flush=1 for 2 cycles.
  - branch=01, equal=0 -> flush=0.
  - branch=10, equal=0 -> flush 2 cycles.
  - branch=11 -> flush 2 cycles.
- Simultaneous hz (rt match, rt=5) and branch=11 -> stall only, flush=0. After the stall, with branch still 11, flush asserts.
- LOAD_LAT=4: drive rst=0 asynchronously during the second stall cycle -> outputs immediately 1/1/1/0, busy=0. After release, no residual stall.
- HAZARD_PERF_CNT_EN, CNT_W=2: 5 stall cycles -> stall_cnt=3 (saturated). 2 flush cycles -> flush_cnt=2.
